cl_rd_ctrl_preafu: RTL and testbench

- Read-side sequencer for the pre-AFU cache-line frame buffer.
- Waits until the buffer reports a complete AFU frame, then issues FIFO read requests for exactly that frame's CL count.
- Forwards CLs to the AFU over a valid/ready stream with sop/eop markers, then pulses the read-finish strobe back to the buffer.
- Absorbs the buffer's 1-cycle read latency and AFU backpressure with a 2-entry output skid.

---
 rtl/cl_rd_ctrl_preafu.sv | 156 +++++++++++++++
 tb/tb_cl_rd_ctrl_preafu.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_rd_ctrl_preafu.sv
// Read-side sequencer for the pre-AFU cache-line frame buffer.
// Latches a frame's CL count, issues FIFO reads under a 2-credit limit,
// streams the CLs to the AFU with sop/eop markers, then pulses finish.
module cl_rd_ctrl_preafu #(
    parameter int CL                  = 512,
    parameter int w_NumOfST_in_AFUFrm = 16,
    parameter int LOG2_ST_PER_CL      = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ff_rd_ready,
    input  logic [w_NumOfST_in_AFUFrm-1:0] sb_len,
    output logic                           ff_rdreq,
    input  logic [CL-1:0]                  ff_q,
    output logic                           ff_rd_finish,
    output logic [CL-1:0]                  source_data,
    output logic                           source_valid,
    input  logic                           source_ready,
    output logic                           source_sop,
    output logic                           source_eop,
    output logic                           busy
);

    localparam int LW = w_NumOfST_in_AFUFrm;
    localparam logic [LW-1:0] LP_REM_MASK = LW'((64'd1 << LOG2_ST_PER_CL) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FIN,
        S_GAP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [LW-1:0]   r_rd_left;
    logic [LW-1:0]   r_out_left;
    logic [LW-1:0]   w_cl_cnt;
    logic            r_first;
    logic            r_inflight;
    logic [CL-1:0]   r_skid [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_skid_cnt;
    logic            w_latch;
    logic            w_rdreq;
    logic            w_valid;
    logic            w_pop;
    logic            w_skid_wr;
    logic            w_skid_pop;

    // ceil(sb_len / 2^LOG2): whole CLs plus one for any partial remainder
    assign w_cl_cnt = (sb_len >> LOG2_ST_PER_CL) + LW'(|(sb_len & LP_REM_MASK));

    // The read in flight is treated as a virtual head entry: its data is
    // presented straight from ff_q and only lands in the skid if not taken.
    assign w_valid    = (r_skid_cnt != 2'd0) | r_inflight;
    assign w_pop      = w_valid & source_ready;
    assign w_skid_pop = w_pop & (r_skid_cnt != 2'd0);
    assign w_skid_wr  = r_inflight & ~(w_pop & (r_skid_cnt == 2'd0));

    assign source_valid = w_valid;
    assign source_data  = (r_skid_cnt != 2'd0) ? r_skid[r_rd_ptr] :
                          (r_inflight ? ff_q : '0);
    assign source_sop   = w_valid & r_first;
    assign source_eop   = w_valid & (r_out_left == LW'(1));
    assign ff_rdreq     = w_rdreq;
    assign ff_rd_finish = (r_state == S_FIN);
    assign busy         = (r_state == S_READ) | (r_state == S_DRAIN) | (r_state == S_FIN);

    // Next-state and read-request decode
    always_comb begin
        w_state_nxt = r_state;
        w_rdreq     = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ff_rd_ready) begin
                    w_latch = 1'b1;
                    // Zero-length frames pass through DRAIN so the finish
                    // pulse keeps the same two-cycle distance from the latch.
                    w_state_nxt = (w_cl_cnt == '0) ? S_DRAIN : S_READ;
                end
            end
            S_READ: begin
                w_rdreq = (r_rd_left != '0) &&
                          (({1'b0, r_skid_cnt} + {2'b00, r_inflight}) < 3'd2);
                if ((r_rd_left == '0) || ((r_rd_left == LW'(1)) && w_rdreq))
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if ((r_out_left == '0) || ((r_out_left == LW'(1)) && w_pop))
                    w_state_nxt = S_FIN;
            end
            S_FIN:   w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Frame counters, first-beat flag and read-in-flight tracker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_left  <= '0;
            r_out_left <= '0;
            r_first    <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rdreq;
            if (w_latch) begin
                r_rd_left  <= w_cl_cnt;
                r_out_left <= w_cl_cnt;
                r_first    <= 1'b1;
            end else begin
                if (w_rdreq) r_rd_left <= r_rd_left - LW'(1);
                if (w_pop) begin
                    r_out_left <= r_out_left - LW'(1);
                    r_first    <= 1'b0;
                end
            end
        end
    end

    // Two-entry output skid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid[0]  <= '0;
            r_skid[1]  <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_skid_cnt <= 2'd0;
        end else begin
            if (w_skid_wr) begin
                r_skid[r_wr_ptr] <= ff_q;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_skid_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_skid_wr, w_skid_pop})
                2'b10:   r_skid_cnt <= r_skid_cnt + 2'd1;
                2'b01:   r_skid_cnt <= r_skid_cnt - 2'd1;
                default: r_skid_cnt <= r_skid_cnt;
            endcase
        end
    end

    ap_skid_bound: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, r_skid_cnt} + {2'b00, r_inflight}) <= 3'd2);

endmodule

// File: tb/tb_cl_rd_ctrl_preafu.sv
// Scoreboard bench for cl_rd_ctrl_preafu: two instances (LOG2=0 and LOG2=2)
// fed by a behavioural frame-buffer model; a negedge monitor checks beats,
// handshake timing, read counts and finish pulses against queued expectations.
module tb_cl_rd_ctrl_preafu;

    localparam int CLW = 64;
    localparam int LW  = 16;

    typedef struct packed {
        logic [CLW-1:0] d;
        logic           s;
        logic           e;
    } beat_t;

    typedef struct packed {
        logic [31:0] cnt;
        logic        full;
    } finfo_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           rdy    [2];
    logic [LW-1:0]  slen   [2];
    logic           rdreq  [2];
    logic [CLW-1:0] q      [2];
    logic           fin    [2];
    logic [CLW-1:0] sdata  [2];
    logic           svalid [2];
    logic           sready [2];
    logic           ssop   [2];
    logic           seop   [2];
    logic           sbusy  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        cl_rd_ctrl_preafu #(
            .CL                  (CLW),
            .w_NumOfST_in_AFUFrm (LW),
            .LOG2_ST_PER_CL      (2 * g)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .ff_rd_ready  (rdy[g]),
            .sb_len       (slen[g]),
            .ff_rdreq     (rdreq[g]),
            .ff_q         (q[g]),
            .ff_rd_finish (fin[g]),
            .source_data  (sdata[g]),
            .source_valid (svalid[g]),
            .source_ready (sready[g]),
            .source_sop   (ssop[g]),
            .source_eop   (seop[g]),
            .busy         (sbusy[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mode [2];

    beat_t          exp_q    [2][$];
    finfo_t         finfo_q  [2][$];
    logic [CLW-1:0] buf_data [2][$];
    int             frm_len  [2][$];

    // monitor state
    bit             prev_busy  [2];
    bit             prev_valid [2];
    bit             prev_ready [2];
    bit             prev_fin   [2];
    logic [CLW-1:0] prev_data  [2];
    bit             in_frame   [2];
    bit             first_seen [2];
    bit             pend_next  [2];
    finfo_t         cur        [2];
    int             latch_cyc  [2];
    int             eop_cyc    [2];
    int             fin_cyc    [2];
    int             rdreq_cnt  [2];
    int             beats      [2];
    int             busy_cnt   [2];

    task automatic check(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @cyc %0d: got %0h expected %0h", nm, i, cyc, act, exp);
        end
    endtask

    function automatic int cl_count(input int len, input int l2);
        int per;
        per = 1 << l2;
        return (len + per - 1) / per;
    endfunction

    task automatic add_frame(input int i, input int len, input bit full);
        int     n;
        finfo_t f;
        beat_t  b;
        logic [CLW-1:0] d;
        n = cl_count(len, 2 * i);
        frm_len[i].push_back(len);
        f.cnt  = n;
        f.full = full;
        finfo_q[i].push_back(f);
        for (int k = 0; k < n; k++) begin
            d = {$urandom, $urandom};
            buf_data[i].push_back(d);
            b.d = d;
            b.s = (k == 0);
            b.e = (k == n - 1);
            exp_q[i].push_back(b);
        end
    endtask

    task automatic flush(input int i);
        exp_q[i].delete();
        finfo_q[i].delete();
        buf_data[i].delete();
        frm_len[i].delete();
    endtask

    task automatic wait_idle(input int i);
        int k;
        k = 0;
        while ((finfo_q[i].size() != 0 || sbusy[i] || exp_q[i].size() != 0) && k < 400) begin
            @(negedge clk); #2;
            k++;
        end
        if (k >= 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle[%0d]: frame did not complete within 400 cycles", i);
            flush(i);
        end
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic check_zero(input int i);
        check("rst_rdreq",  i, 64'(rdreq[i]),  0);
        check("rst_finish", i, 64'(fin[i]),    0);
        check("rst_valid",  i, 64'(svalid[i]), 0);
        check("rst_sop",    i, 64'(ssop[i]),   0);
        check("rst_eop",    i, 64'(seop[i]),   0);
        check("rst_busy",   i, 64'(sbusy[i]),  0);
        check("rst_data",   i, sdata[i],       0);
    endtask

    // Frame-buffer model: one-cycle read latency, garbage on ff_q when idle
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                rdy[i]  <= 1'b0;
                slen[i] <= '0;
                q[i]    <= '0;
            end else begin
                if (fin[i] && frm_len[i].size() > 0) void'(frm_len[i].pop_front());
                if (rdreq[i] && buf_data[i].size() > 0) q[i] <= buf_data[i].pop_front();
                else q[i] <= {$urandom, $urandom};
                rdy[i]  <= (frm_len[i].size() > 0);
                slen[i] <= (frm_len[i].size() > 0) ? LW'(frm_len[i][0]) : '0;
            end
        end
    end

    // AFU ready driver: 0=always ready, 1=toggle, 2=random, 3=stalled
    initial begin
        sready[0] = 1'b1;
        sready[1] = 1'b1;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                case (mode[i])
                    0:       sready[i] = 1'b1;
                    1:       sready[i] = ~sready[i];
                    2:       sready[i] = 1'($urandom_range(0, 1));
                    default: sready[i] = 1'b0;
                endcase
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        beat_t  b;
        finfo_t f;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                prev_busy[i] = 0; prev_valid[i] = 0; prev_ready[i] = 0; prev_fin[i] = 0;
                in_frame[i] = 0; first_seen[i] = 0; pend_next[i] = 0;
                rdreq_cnt[i] = 0; beats[i] = 0; busy_cnt[i] = 0;
            end else begin
                if (prev_fin[i]) check("post_fin_idle", i, {62'd0, fin[i], sbusy[i]}, 0);
                if (sbusy[i] && !prev_busy[i]) begin
                    latch_cyc[i] = cyc - 1;
                    rdreq_cnt[i] = 0; beats[i] = 0; busy_cnt[i] = 0; first_seen[i] = 0;
                    n_tests++;
                    if (finfo_q[i].size() == 0) begin
                        n_fail++;
                        in_frame[i] = 0;
                        $display("FAIL spurious_latch[%0d] @cyc %0d: got busy 1 expected 0", i, cyc);
                    end else begin
                        cur[i] = finfo_q[i][0];
                        in_frame[i] = 1;
                    end
                    if (pend_next[i]) check("b2b_latch_gap", i, 64'(latch_cyc[i] - fin_cyc[i]), 2);
                    pend_next[i] = 0;
                end
                if (sbusy[i]) busy_cnt[i]++;
                if (rdreq[i]) begin
                    rdreq_cnt[i]++;
                    check("rdreq_in_frame", i, 64'(sbusy[i]), 1);
                end
                if (prev_valid[i] && !prev_ready[i]) begin
                    check("hold_valid", i, 64'(svalid[i]), 1);
                    check("hold_data",  i, sdata[i], prev_data[i]);
                end
                if (svalid[i] && !first_seen[i] && in_frame[i]) begin
                    first_seen[i] = 1;
                    check("first_valid_lat", i, 64'(cyc - latch_cyc[i]), 2);
                end
                if (svalid[i] && sready[i]) begin
                    beats[i]++;
                    if (exp_q[i].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat[%0d] @cyc %0d: got data %0h expected no beat", i, cyc, sdata[i]);
                    end else begin
                        b = exp_q[i].pop_front();
                        check("beat_data", i, sdata[i], b.d);
                        check("beat_sop",  i, 64'(ssop[i]), 64'(b.s));
                        check("beat_eop",  i, 64'(seop[i]), 64'(b.e));
                    end
                    if (seop[i]) begin
                        eop_cyc[i] = cyc;
                        if (in_frame[i] && cur[i].full)
                            check("eop_time", i, 64'(cyc - latch_cyc[i]), 64'(cur[i].cnt + 1));
                    end
                end
                if (fin[i]) begin
                    if (finfo_q[i].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL spurious_finish[%0d] @cyc %0d: got finish 1 expected 0", i, cyc);
                    end else begin
                        f = finfo_q[i].pop_front();
                        check("rdreq_total", i, 64'(rdreq_cnt[i]), 64'(f.cnt));
                        check("beats_total", i, 64'(beats[i]), 64'(f.cnt));
                        if (f.cnt == 0) begin
                            check("fin_after_latch", i, 64'(cyc - latch_cyc[i]), 2);
                            check("busy_len",        i, 64'(busy_cnt[i]), 2);
                        end else begin
                            check("fin_after_eop", i, 64'(cyc - eop_cyc[i]), 1);
                        end
                        pend_next[i] = (frm_len[i].size() > 1);
                        fin_cyc[i]   = cyc;
                    end
                    in_frame[i] = 0;
                end
                prev_busy[i]  = sbusy[i];
                prev_valid[i] = svalid[i];
                prev_ready[i] = sready[i];
                prev_fin[i]   = fin[i];
                prev_data[i]  = sdata[i];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int k;
        int i;
        int m;
        mode[0] = 0;
        mode[1] = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check_zero(0);
        check_zero(1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2;

        // basic 4-CL frame at full rate
        add_frame(0, 4, 1);
        wait_idle(0);
        // 6-CL frame with toggling ready
        mode[0] = 1;
        add_frame(0, 6, 0);
        wait_idle(0);
        // zero-length frame
        mode[0] = 0;
        add_frame(0, 0, 1);
        wait_idle(0);
        // 4 STs per CL: 9 STs -> 3 CLs, 8 STs -> 2 CLs
        add_frame(1, 9, 1);
        wait_idle(1);
        add_frame(1, 8, 1);
        wait_idle(1);
        // two queued frames, ready held high across them
        add_frame(0, 2, 1);
        add_frame(0, 3, 1);
        wait_idle(0);

        // reset in the middle of a 5-CL frame after two reads
        mode[0] = 3;
        add_frame(0, 5, 0);
        k = 0;
        while (rdreq_cnt[0] < 2 && k < 50) begin
            @(negedge clk); #2;
            k++;
        end
        if (k >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL mid_reads[0]: got %0d reads expected 2 within 50 cycles", rdreq_cnt[0]);
        end
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(0);
        flush(0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        mode[0] = 0;
        @(negedge clk); #2;
        add_frame(0, 3, 1);
        wait_idle(0);

        // randomized frames
        for (int f = 0; f < 24; f++) begin
            i = $urandom_range(0, 1);
            m = $urandom_range(0, 2);
            mode[i] = m;
            add_frame(i, $urandom_range(0, 12), m == 0);
            if ($urandom_range(0, 3) == 0) add_frame(i, $urandom_range(0, 12), m == 0);
            wait_idle(i);
        end

        check("leftover_beats", 0, 64'(exp_q[0].size()), 0);
        check("leftover_beats", 1, 64'(exp_q[1].size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
